// File: rtl/battleship_pkg.sv
// Shared types for the Battleship board controller.
//   cell_t  : per-cell board state, also the renderer read-back encoding
//   phase_t : game phase reported by the board controller
package battleship_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        PH_DECIDE = 2'd0,
        PH_PLACE  = 2'd1,
        PH_PLAY   = 2'd2,
        PH_OVER   = 2'd3
    } phase_t;

    // A cell that has already taken a shot cannot be shot again.
    function automatic logic is_shot_cell(cell_t c);
        return (c == CELL_HIT) || (c == CELL_MISS);
    endfunction

endpackage

// File: rtl/battleship_board_ctrl_if.sv
// Shot handshake between the game FSM (master) and the board controller (slave).
//   shot_valid, shot_i, shot_j : shot request and target row/column
//   shot_ready                 : board accepts shots (play phase only)
//   shot_done                  : one-cycle result strobe, one cycle after acceptance
//   shot_hit, shot_invalid     : result qualifiers, valid with shot_done
interface battleship_board_ctrl_if #(
    parameter int unsigned BOARD_N = 5,
    parameter int unsigned IDX_W   = $clog2(BOARD_N)
);
    logic             shot_valid;
    logic [IDX_W-1:0] shot_i;
    logic [IDX_W-1:0] shot_j;
    logic             shot_ready;
    logic             shot_done;
    logic             shot_hit;
    logic             shot_invalid;

    modport master (
        output shot_valid, shot_i, shot_j,
        input  shot_ready, shot_done, shot_hit, shot_invalid
    );

    modport slave (
        input  shot_valid, shot_i, shot_j,
        output shot_ready, shot_done, shot_hit, shot_invalid
    );
endinterface

// File: rtl/battleship_cursor.sv
// Board cursor: one step per cycle from one-cycle move pulses.
//   clk, rst                 : clock, async active-high reset (cursor -> (0,0))
//   enable                   : moves are ignored while low
//   move_up/down/left/right  : move pulses, priority up > down > left > right
//   cursor_i, cursor_j       : registered row/column
// Build option BATTLESHIP_CURSOR_WRAP_EN: wrap at the grid edges instead of saturating.
module battleship_cursor #(
    parameter int unsigned BOARD_N = 5,
    parameter int unsigned IDX_W   = $clog2(BOARD_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             move_up,
    input  logic             move_down,
    input  logic             move_left,
    input  logic             move_right,
    output logic [IDX_W-1:0] cursor_i,
    output logic [IDX_W-1:0] cursor_j
);

`ifdef BATTLESHIP_CURSOR_WRAP_EN
    localparam bit Wrap = 1'b1;
`else
    localparam bit Wrap = 1'b0;
`endif

    localparam logic [IDX_W-1:0] Last = IDX_W'(BOARD_N - 1);
    localparam logic [IDX_W-1:0] One  = IDX_W'(1);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (enable) begin
            if (move_up) begin
                if (i_q == '0) i_d = Wrap ? Last : '0;
                else           i_d = i_q - One;
            end else if (move_down) begin
                if (i_q == Last) i_d = Wrap ? '0 : Last;
                else             i_d = i_q + One;
            end else if (move_left) begin
                if (j_q == '0) j_d = Wrap ? Last : '0;
                else           j_d = j_q - One;
            end else if (move_right) begin
                if (j_q == Last) j_d = Wrap ? '0 : Last;
                else             j_d = j_q + One;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign cursor_i = i_q;
    assign cursor_j = j_q;

endmodule

// File: rtl/battleship_board_ctrl.sv
// Board controller for one Battleship player board (NxN grid, single-cell ships).
//   clk, rst                 : clock, async active-high reset
//   move_up/down/left/right  : cursor pulses (disabled in PH_OVER)
//   confirm                  : accept ship count / place ship / restart
//   ships_req                : requested ship count, clamped to 1..MAX_SHIPS
//   shot_bus                 : shot handshake (slave side)
//   cursor_i, cursor_j       : cursor position
//   phase                    : current phase_t
//   ships_target/placed/left : ship counters
//   placement_error          : one-cycle pulse on placement onto an occupied cell
//   all_sunk                 : high in PH_OVER
//   rd_i, rd_j, rd_cell      : combinational renderer read port (CELL_EMPTY out of range)
// Build option BATTLESHIP_CURSOR_WRAP_EN: see battleship_cursor.
module battleship_board_ctrl
    import battleship_pkg::*;
#(
    parameter int unsigned BOARD_N   = 5,
    parameter int unsigned MAX_SHIPS = 5,
    parameter int unsigned IDX_W     = $clog2(BOARD_N),
    parameter int unsigned SHIP_W    = $clog2(MAX_SHIPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_up,
    input  logic                 move_down,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic                 confirm,
    input  logic [SHIP_W-1:0]    ships_req,
    battleship_board_ctrl_if.slave shot_bus,
    output logic [IDX_W-1:0]     cursor_i,
    output logic [IDX_W-1:0]     cursor_j,
    output phase_t               phase,
    output logic [SHIP_W-1:0]    ships_target,
    output logic [SHIP_W-1:0]    ships_placed,
    output logic [SHIP_W-1:0]    ships_left,
    output logic                 placement_error,
    output logic                 all_sunk,
    input  logic [IDX_W-1:0]     rd_i,
    input  logic [IDX_W-1:0]     rd_j,
    output cell_t                rd_cell
);

    localparam logic [SHIP_W-1:0] MaxShips = SHIP_W'(MAX_SHIPS);
    localparam logic [SHIP_W-1:0] OneShip  = SHIP_W'(1);

    phase_t phase_q, phase_d;
    cell_t  board_q [BOARD_N][BOARD_N];

    logic [SHIP_W-1:0] ships_target_q, ships_placed_q, ships_left_q;
    logic              placement_error_q, shot_done_q, shot_hit_q, shot_invalid_q;

    logic              shot_ready, cursor_en;
    logic [SHIP_W-1:0] ships_clamped, ships_placed_inc;
    cell_t             cursor_cell, shot_cell;
    logic              place_ok, place_err, place_last;
    logic              shot_accept, shot_in_range, shot_hit_now, shot_miss_now, shot_bad_now;
    logic [IDX_W-1:0]  shot_row, shot_col;

    battleship_cursor #(
        .BOARD_N (BOARD_N),
        .IDX_W   (IDX_W)
    ) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .enable     (cursor_en),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .cursor_i   (cursor_i),
        .cursor_j   (cursor_j)
    );

    // Decode of the current inputs against the board; shared by FSM and datapath.
    always_comb begin
        if (ships_req == '0)           ships_clamped = OneShip;
        else if (ships_req > MaxShips) ships_clamped = MaxShips;
        else                           ships_clamped = ships_req;

        cursor_cell      = board_q[cursor_i][cursor_j];
        ships_placed_inc = ships_placed_q + OneShip;
        place_ok         = (phase_q == PH_PLACE) && confirm && (cursor_cell == CELL_EMPTY);
        place_err        = (phase_q == PH_PLACE) && confirm && (cursor_cell != CELL_EMPTY);
        place_last       = (ships_placed_inc == ships_target_q);

        shot_in_range = (int'(shot_bus.shot_i) < BOARD_N) && (int'(shot_bus.shot_j) < BOARD_N);
        // Out-of-range coordinates are redirected to a legal index; the result is discarded.
        shot_row      = shot_in_range ? shot_bus.shot_i : '0;
        shot_col      = shot_in_range ? shot_bus.shot_j : '0;
        shot_cell     = board_q[shot_row][shot_col];
        shot_accept   = shot_bus.shot_valid && shot_ready;
        shot_hit_now  = shot_accept && shot_in_range && (shot_cell == CELL_SHIP);
        shot_miss_now = shot_accept && shot_in_range && (shot_cell == CELL_EMPTY);
        shot_bad_now  = shot_accept && (!shot_in_range || is_shot_cell(shot_cell));
    end

    // Phase FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= PH_DECIDE;
        else     phase_q <= phase_d;
    end

    // Phase FSM: next state. Transitions coincide with the counter update that triggers them.
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_DECIDE: if (confirm) phase_d = PH_PLACE;
            PH_PLACE:  if (place_ok && place_last) phase_d = PH_PLAY;
            PH_PLAY:   if (shot_hit_now && (ships_left_q == OneShip)) phase_d = PH_OVER;
            PH_OVER:   if (confirm) phase_d = PH_DECIDE;
        endcase
    end

    // Phase FSM: outputs.
    always_comb begin
        shot_ready = (phase_q == PH_PLAY);
        all_sunk   = (phase_q == PH_OVER);
        cursor_en  = (phase_q != PH_OVER);
    end

    // Board array, counters and result strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < BOARD_N; r++) begin
                for (int c = 0; c < BOARD_N; c++) begin
                    board_q[r][c] <= CELL_EMPTY;
                end
            end
            ships_target_q    <= '0;
            ships_placed_q    <= '0;
            ships_left_q      <= '0;
            placement_error_q <= 1'b0;
            shot_done_q       <= 1'b0;
            shot_hit_q        <= 1'b0;
            shot_invalid_q    <= 1'b0;
        end else begin
            placement_error_q <= place_err;
            shot_done_q       <= shot_accept;
            shot_hit_q        <= shot_hit_now;
            shot_invalid_q    <= shot_bad_now;

            if ((phase_q == PH_DECIDE) && confirm) begin
                ships_target_q <= ships_clamped;
            end

            if (place_ok) begin
                board_q[cursor_i][cursor_j] <= CELL_SHIP;
                ships_placed_q              <= ships_placed_inc;
                if (place_last) ships_left_q <= ships_target_q;
            end

            if (shot_hit_now) begin
                board_q[shot_row][shot_col] <= CELL_HIT;
                ships_left_q                <= ships_left_q - OneShip;
            end else if (shot_miss_now) begin
                board_q[shot_row][shot_col] <= CELL_MISS;
            end

            if ((phase_q == PH_OVER) && confirm) begin
                for (int r = 0; r < BOARD_N; r++) begin
                    for (int c = 0; c < BOARD_N; c++) begin
                        board_q[r][c] <= CELL_EMPTY;
                    end
                end
                ships_target_q <= '0;
                ships_placed_q <= '0;
                ships_left_q   <= '0;
            end
        end
    end

    assign rd_cell = ((int'(rd_i) < BOARD_N) && (int'(rd_j) < BOARD_N)) ? board_q[rd_i][rd_j]
                                                                         : CELL_EMPTY;

    assign phase                 = phase_q;
    assign ships_target          = ships_target_q;
    assign ships_placed          = ships_placed_q;
    assign ships_left            = ships_left_q;
    assign placement_error       = placement_error_q;
    assign shot_bus.shot_ready   = shot_ready;
    assign shot_bus.shot_done    = shot_done_q;
    assign shot_bus.shot_hit     = shot_hit_q;
    assign shot_bus.shot_invalid = shot_invalid_q;

endmodule

// File: doc/battleship_board_ctrl.md
# battleship_board_ctrl

Parametrised board controller for one Battleship player board: NxN grid, 1..MAX_SHIPS single-cell ships, cursor-driven placement with error reporting, then a shot-resolution phase with hit/miss/invalid responses and all-sunk detection. Sits between the debounced button/switch logic and the game FSM and VGA renderer. It replaces the fixed 5x5, 5-ship board handling with a configurable grid, a ship counter and a shot handshake.

## Interface
- BOARD_N, 5: grid side length, 2..16
- MAX_SHIPS, 5: upper clamp on requested ships, 1..BOARD_N*BOARD_N
- IDX_W, $clog2(BOARD_N): coordinate width (derived)
- SHIP_W, $clog2(MAX_SHIPS+1): ship-count width (derived)

One clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  async active-high reset
- move_up, move_down, move_left, move_right  in  1 each  one-cycle cursor pulses
- confirm  in  1  one-cycle pulse: accept count / place ship / restart
- ships_req  in  SHIP_W  requested ship count, sampled on confirm in PH_DECIDE
- shot_valid  in  1  incoming shot request
- shot_i, shot_j  in  IDX_W  shot row/column
- shot_ready  out  1  high only in PH_PLAY
- shot_done  out  1  one-cycle result strobe
- shot_hit  out  1  valid with shot_done: ship cell struck
- shot_invalid  out  1  valid with shot_done: out of range or already shot
- cursor_i, cursor_j  out  IDX_W  cursor position
- phase  out  2  current phase_t
- ships_target, ships_placed, ships_left  out  SHIP_W  counters
- placement_error  out  1  one-cycle pulse on illegal placement
- all_sunk  out  1  level, high in PH_OVER
- rd_i, rd_j  in  IDX_W  renderer read address
- rd_cell  out  2  combinational cell_t at (rd_i, rd_j); CELL_EMPTY if out of range

## Operation
- Phases: PH_DECIDE -> PH_PLACE -> PH_PLAY -> PH_OVER -> PH_DECIDE.
- PH_DECIDE: confirm latches ships_target = clamp(ships_req, 1, MAX_SHIPS); the board is already all CELL_EMPTY; go to PH_PLACE.
- PH_PLACE: on confirm, if cell at cursor is CELL_EMPTY, write CELL_SHIP and increment ships_placed. Otherwise pulse placement_error and leave the board unchanged. When ships_placed reaches ships_target, go to PH_PLAY and set ships_left = ships_target.
- PH_PLAY: a shot is accepted when shot_valid && shot_ready.
  - Out of range (either coordinate >= BOARD_N) or a CELL_HIT/CELL_MISS cell: shot_invalid=1, board unchanged.
  - CELL_SHIP: write CELL_HIT, shot_hit=1, decrement ships_left.
  - CELL_EMPTY: write CELL_MISS.
  - When ships_left reaches 0, go to PH_OVER.
- PH_OVER: all_sunk=1 and shots are ignored. confirm clears the board and counters and returns to PH_DECIDE.
- Cursor: active in all phases except PH_OVER, one step per cycle. When several move pulses arrive together, priority is up > down > left > right and only one applies. Up decrements i; left decrements j.
- confirm in PH_DECIDE/PH_OVER is ignored outside those phases' rules; confirm in PH_PLAY is ignored.

## Timing
- Reset values:
  - phase=PH_DECIDE; cursor=(0,0); all cells CELL_EMPTY.
  - ships_target/placed/left=0.
  - shot_done, shot_hit, shot_invalid, placement_error=0; all_sunk=0.
  - shot_ready=0.
- Cursor moves are visible the cycle after the pulse.
- confirm and a move in the same cycle: placement uses the pre-move cursor, and the move still applies.
- Placement: cell write, ships_placed and placement_error all register 1 cycle after confirm.
- Phase changes register on the same edge as the counter that triggers them.
- Shot latency: shot_done is asserted exactly 1 cycle after acceptance. shot_ready drops in the cycle the last ship is sunk, so no shot is accepted in PH_OVER.
- Back-to-back shots on consecutive cycles are accepted, one result per cycle.
- Reset mid-operation returns everything to reset values asynchronously.

## Configuration
- BATTLESHIP_CURSOR_WRAP_EN defined: the cursor wraps at the grid edges (row 0 up -> BOARD_N-1; column BOARD_N-1 right -> 0).
- Not defined: the cursor saturates at the edges.

## Structure
- Package battleship_pkg holds:
  - cell_t enum: CELL_EMPTY=2'b00, CELL_SHIP=2'b01, CELL_HIT=2'b10, CELL_MISS=2'b11.
  - phase_t enum: PH_DECIDE=0, PH_PLACE=1, PH_PLAY=2, PH_OVER=3.
- Sub-module battleship_cursor: move priority, wrap/saturate and enable logic, parametrised on BOARD_N. The board array, counters and phase FSM stay in the top.

## Test plan
- BOARD_N=5, reset, ships_req=7, confirm: ships_target=5 (clamped), phase=PH_PLACE. With ships_req=0: ships_target=1.
- Place at (0,0), then confirm again at (0,0): placement_error pulses 1 cycle, ships_placed stays 1, rd_cell(0,0)=CELL_SHIP.
- Cursor at (0,0) with move_up: (4,0) with the wrap macro, (0,0) without. move_up+move_left together: only the row changes.
- PH_PLAY with 2 ships at (1,1) and (2,3):
  - shot (1,1): shot_hit=1, ships_left=1.
  - shot (1,1) again: shot_invalid=1.
  - shot (0,4): miss, rd_cell=CELL_MISS.
  - shot (5,0): shot_invalid=1.
- Sink the last ship: shot_done next cycle, phase=PH_OVER, all_sunk=1, shot_ready=0. confirm: board all CELL_EMPTY, phase=PH_DECIDE.
- Assert rst mid-PH_PLAY: all outputs at reset values immediately, without waiting for a clk edge.
